icache: RTL and testbench

- Direct-mapped instruction cache between the instruction-fetch unit and the memory controller.
- Serves fetch requests from local storage on a hit.
- On a miss, issues a single-word fetch on the ic_valid/ic_enable handshake, fills the line, then answers the fetch unit.
- One word (4 bytes) per line; read-only; no write path.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_array.sv | 56 +++++
 rtl/icache.sv | 139 +++++++++++++
 tb/tb_icache.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared configuration for the direct-mapped instruction cache:
// default geometry, logic levels and control FSM state encodings.
package icache_pkg;

    localparam int ICACHE_IDX_W = 8;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Line storage for the instruction cache: resettable valid bits plus
// unreset tag/data arrays, one combinational read port and one write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = HIGH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache: 1-cycle hits, and a
// single-word refill through the ic_valid/ic_enable handshake on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic        ic_valid,
    output logic [31:0] addr_from_ic,
    input  logic        ic_enable,
    input  logic [31:0] inst_to_ic
);

    localparam int TAG_W = 30 - IDX_W;

    state_e             state_q, state_d;
    logic               inst_valid_q, inst_valid_d;
    logic [31:0]        inst_out_q, inst_out_d;
    logic               ic_valid_q, ic_valid_d;
    logic [31:0]        addr_q, addr_d;
    logic               discard_q, discard_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               fill;
    logic               accept;
    logic               hit;
    logic               unused_addr_lsb;

    assign req_idx         = if_addr[IDX_W+1:2];
    assign req_tag         = if_addr[31:IDX_W+2];
    assign unused_addr_lsb = ^if_addr[1:0];

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_idx   (miss_idx_q),
        .wr_tag   (miss_tag_q),
        .wr_data  (inst_to_ic)
    );

    // A held request is not re-accepted while its own response is showing.
    assign accept = (state_q == ST_IDLE) && if_req && !clear && !inst_valid_q;
    assign hit    = rd_valid && (rd_tag == req_tag);
    assign fill   = rdy && (state_q == ST_MISS) && ic_enable;

    always_comb begin
        state_d      = state_q;
        inst_valid_d = LOW;
        inst_out_d   = inst_out_q;
        ic_valid_d   = ic_valid_q;
        addr_d       = addr_q;
        discard_d    = discard_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        inst_valid_d = HIGH;
                        inst_out_d   = rd_data;
                    end else begin
                        ic_valid_d = HIGH;
                        addr_d     = {if_addr[31:2], 2'b00};
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        discard_d  = LOW;
                        state_d    = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                // The refill cannot be aborted; a flush only drops the answer.
                if (clear) begin
                    discard_d = HIGH;
                end
                if (ic_enable) begin
                    ic_valid_d = LOW;
                    addr_d     = '0;
                    discard_d  = LOW;
                    state_d    = ST_IDLE;
                    if (!discard_q && !clear) begin
                        inst_valid_d = HIGH;
                        inst_out_d   = inst_to_ic;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_valid_q <= LOW;
            inst_out_q   <= '0;
            ic_valid_q   <= LOW;
            addr_q       <= '0;
            discard_q    <= LOW;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            ic_valid_q   <= ic_valid_d;
            addr_q       <= addr_d;
            discard_q    <= discard_d;
            miss_idx_q   <= miss_idx_d;
            miss_tag_q   <= miss_tag_d;
        end
    end

    assign inst_valid   = inst_valid_q;
    assign inst_out     = inst_out_q;
    assign ic_valid     = ic_valid_q;
    assign addr_from_ic = addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: linear sequence of steps with hand-computed
// expectations checked by immediate assertions.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic        ic_valid;
    logic [31:0] addr_from_ic;
    logic        ic_enable;
    logic [31:0] inst_to_ic;

    int nvec;
    int nerr;

    icache #(.IDX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .ic_valid     (ic_valid),
        .addr_from_ic (addr_from_ic),
        .ic_enable    (ic_enable),
        .inst_to_ic   (inst_to_ic)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        rst        = 1'b1;
        rdy        = 1'b1;
        clear      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        ic_enable  = 1'b0;
        inst_to_ic = '0;

        // Reset state
        repeat (2) step();
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_ic_valid", {31'd0, ic_valid}, 32'd0);
        chk("rst_addr", addr_from_ic, 32'd0);
        rst = 1'b0;
        step();

        // Cold miss on 0x4 and fill
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        step();
        chk("miss4_ic_valid", {31'd0, ic_valid}, 32'd1);
        chk("miss4_addr", addr_from_ic, 32'h0000_0004);
        chk("miss4_no_inst", {31'd0, inst_valid}, 32'd0);
        ic_enable  = 1'b1;
        inst_to_ic = 32'h0010_0093;
        step();
        chk("fill4_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("fill4_inst_out", inst_out, 32'h0010_0093);
        chk("fill4_ic_valid", {31'd0, ic_valid}, 32'd0);
        chk("fill4_addr", addr_from_ic, 32'd0);
        ic_enable = 1'b0;
        if_req    = 1'b0;
        step();
        chk("fill4_pulse_end", {31'd0, inst_valid}, 32'd0);

        // Hit on 0x4, request held through response to check re-accept blocking
        if_req = 1'b1;
        step();
        chk("hit4_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("hit4_inst_out", inst_out, 32'h0010_0093);
        chk("hit4_no_miss", {31'd0, ic_valid}, 32'd0);
        step();
        chk("hit4_blocked", {31'd0, inst_valid}, 32'd0);
        step();
        chk("hit4_reaccept", {31'd0, inst_valid}, 32'd1);
        chk("hit4b_no_miss", {31'd0, ic_valid}, 32'd0);
        if_req = 1'b0;
        step();

        // Conflict: 0x404 shares index 1 with 0x4
        if_req  = 1'b1;
        if_addr = 32'h0000_0404;
        step();
        chk("miss404_ic_valid", {31'd0, ic_valid}, 32'd1);
        chk("miss404_addr", addr_from_ic, 32'h0000_0404);
        ic_enable  = 1'b1;
        inst_to_ic = 32'hDEAD_BEEF;
        step();
        chk("fill404_inst_out", inst_out, 32'hDEAD_BEEF);
        chk("fill404_inst_valid", {31'd0, inst_valid}, 32'd1);
        ic_enable = 1'b0;
        if_req    = 1'b0;
        step();
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        step();
        chk("evict4_ic_valid", {31'd0, ic_valid}, 32'd1);
        chk("evict4_addr", addr_from_ic, 32'h0000_0004);
        chk("evict4_no_inst", {31'd0, inst_valid}, 32'd0);
        ic_enable  = 1'b1;
        inst_to_ic = 32'h0010_0093;
        step();
        chk("refill4_inst_out", inst_out, 32'h0010_0093);
        ic_enable = 1'b0;
        if_req    = 1'b0;
        step();

        // clear during miss on 0x10: fill happens, response is discarded
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        step();
        chk("miss10_ic_valid", {31'd0, ic_valid}, 32'd1);
        clear  = 1'b1;
        if_req = 1'b0;
        step();
        chk("clr10_ic_valid_held", {31'd0, ic_valid}, 32'd1);
        chk("clr10_addr_held", addr_from_ic, 32'h0000_0010);
        clear = 1'b0;
        step();
        chk("clr10_ic_valid_held2", {31'd0, ic_valid}, 32'd1);
        ic_enable  = 1'b1;
        inst_to_ic = 32'h1234_5678;
        step();
        chk("clr10_no_inst", {31'd0, inst_valid}, 32'd0);
        chk("clr10_ic_valid_low", {31'd0, ic_valid}, 32'd0);
        ic_enable = 1'b0;
        step();
        chk("clr10_still_no_inst", {31'd0, inst_valid}, 32'd0);
        if_req = 1'b1;
        step();
        chk("hit10_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("hit10_inst_out", inst_out, 32'h1234_5678);
        chk("hit10_no_miss", {31'd0, ic_valid}, 32'd0);
        if_req = 1'b0;
        step();

        // rdy=0 freezes a miss on 0x20, ic_enable ignored while frozen
        if_req  = 1'b1;
        if_addr = 32'h0000_0020;
        step();
        chk("miss20_ic_valid", {31'd0, ic_valid}, 32'd1);
        if_req     = 1'b0;
        rdy        = 1'b0;
        inst_to_ic = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            ic_enable = (i == 2);
            step();
            chk("frz_ic_valid", {31'd0, ic_valid}, 32'd1);
            chk("frz_no_inst", {31'd0, inst_valid}, 32'd0);
        end
        rdy = 1'b1;
        step();
        chk("thaw_ic_valid", {31'd0, ic_valid}, 32'd1);
        chk("thaw_addr", addr_from_ic, 32'h0000_0020);
        ic_enable = 1'b1;
        step();
        chk("fill20_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("fill20_inst_out", inst_out, 32'hCAFE_F00D);
        chk("fill20_ic_valid", {31'd0, ic_valid}, 32'd0);
        ic_enable = 1'b0;
        step();

        // Async reset mid-miss on 0x30 drops ic_valid immediately
        if_req  = 1'b1;
        if_addr = 32'h0000_0030;
        step();
        chk("miss30_ic_valid", {31'd0, ic_valid}, 32'd1);
        if_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ic_valid", {31'd0, ic_valid}, 32'd0);
        chk("arst_addr", addr_from_ic, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Valid bits were cleared: 0x4 must miss again
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        step();
        chk("post_rst_miss4", {31'd0, ic_valid}, 32'd1);
        chk("post_rst_addr4", addr_from_ic, 32'h0000_0004);
        chk("post_rst_no_hit", {31'd0, inst_valid}, 32'd0);
        ic_enable  = 1'b1;
        inst_to_ic = 32'h0010_0093;
        step();
        chk("post_rst_fill", inst_out, 32'h0010_0093);
        ic_enable = 1'b0;
        if_req    = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
